// File: rtl/nebula_pkg.sv
// Shared Nebula NoC types: flit header layout, credit return record and VC buffer lock states.
package nebula_pkg;

  localparam int NEBULA_NUM_VC_CLASSES = 7;
  localparam int FLIT_PAYLOAD_W        = 32;

  typedef struct packed {
    logic head;
    logic tail;
  } flit_hdr_t;

  localparam int FLIT_HDR_W   = $bits(flit_hdr_t);
  localparam int FLIT_W       = FLIT_HDR_W + FLIT_PAYLOAD_W;
  localparam int HDR_TAIL_BIT = FLIT_PAYLOAD_W;
  localparam int HDR_HEAD_BIT = FLIT_PAYLOAD_W + 1;

  typedef struct packed {
    logic       valid;
    logic [7:0] vc;
  } credit_t;

  typedef enum logic {
    IDLE,
    LOCKED
  } lock_state_t;

  function automatic flit_hdr_t flit_hdr(input logic [FLIT_W-1:0] flit);
    flit_hdr_t hdr;
    hdr.head = flit[HDR_HEAD_BIT];
    hdr.tail = flit[HDR_TAIL_BIT];
    return hdr;
  endfunction

endpackage

// File: rtl/nebula_vc_fifo.sv
// Single-VC first-word-fall-through FIFO; a push to a full FIFO is accepted only alongside a pop.
module nebula_vc_fifo #(
  parameter int DEPTH  = 4,
  parameter int FLIT_W = 34
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [FLIT_W-1:0]        push_flit,
  output logic [FLIT_W-1:0]        head_flit,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_flit = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; contents are only observed through count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_flit;
  end

endmodule

// File: rtl/nebula_vc_buffer.sv
// Per-VC input buffer with round-robin output arbitration, wormhole locking and credit return.
// Optional zero-latency bypass into an idle buffer: NEBULA_VCBUF_BYPASS_EN.
module nebula_vc_buffer
  import nebula_pkg::*;
#(
  parameter int NUM_VC = 7,
  parameter int DEPTH  = 4,
  parameter int FLIT_W = nebula_pkg::FLIT_W,
  parameter int VC_W   = $clog2(NUM_VC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [VC_W-1:0]   in_vc,
  input  logic [FLIT_W-1:0] in_flit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VC_W-1:0]   out_vc,
  output logic [FLIT_W-1:0] out_flit,
  output credit_t           credit_o,
  output logic [NUM_VC-1:0] vc_empty,
  output logic              err_overflow,
  output logic              err_badvc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [FLIT_W-1:0] vc_head  [NUM_VC];
  logic [CNT_W-1:0]  vc_count [NUM_VC];
  logic [NUM_VC-1:0] vc_full, vc_req, push_vec, pop_vec;
  lock_state_t       state, state_nxt;
  logic [VC_W-1:0]   lock_vc, rr_ptr, stall_vc, grant_vc, rr_vc, rr_next;
  logic              stall_q, rr_found, fifo_valid, in_vc_ok, locked;
  logic              bypass, pop_fire, fifo_pop, push_en, overflow_hit;
  flit_hdr_t         out_hdr;

  for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
    nebula_vc_fifo #(.DEPTH(DEPTH), .FLIT_W(FLIT_W)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_vec[g]),
      .pop       (pop_vec[g]),
      .push_flit (in_flit),
      .head_flit (vc_head[g]),
      .full      (vc_full[g]),
      .empty     (vc_empty[g]),
      .count     (vc_count[g])
    );
    assign vc_req[g] = |vc_count[g];
  end

  assign in_vc_ok = int'(in_vc) < NUM_VC;

  // Lock FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Lock FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop_fire && out_hdr.head && !out_hdr.tail) state_nxt = LOCKED;
      LOCKED:  if (pop_fire && out_hdr.tail) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lock FSM: outputs
  always_comb begin
    locked = (state == LOCKED);
  end

  always_comb begin
    rr_vc    = '0;
    rr_found = 1'b0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (!rr_found && vc_req[VC_W'((int'(rr_ptr) + i) % NUM_VC)]) begin
        rr_found = 1'b1;
        rr_vc    = VC_W'((int'(rr_ptr) + i) % NUM_VC);
      end
    end
  end

  // A stalled grant stays put so the presented flit cannot change under the receiver.
  always_comb begin
    grant_vc   = rr_vc;
    fifo_valid = rr_found;
    if (locked) begin
      grant_vc   = lock_vc;
      fifo_valid = vc_req[lock_vc];
    end else if (stall_q) begin
      grant_vc   = stall_vc;
      fifo_valid = vc_req[stall_vc];
    end
  end

`ifdef NEBULA_VCBUF_BYPASS_EN
  assign bypass = !locked && (&vc_empty) && in_valid && in_vc_ok;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = bypass || fifo_valid;
  assign out_vc    = bypass ? in_vc : grant_vc;
  assign out_flit  = bypass ? in_flit : vc_head[grant_vc];
  assign out_hdr   = flit_hdr(out_flit);
  assign pop_fire  = out_valid && out_ready;
  assign fifo_pop  = pop_fire && !bypass;
  assign push_en   = in_valid && in_vc_ok && !(bypass && out_ready);
  assign rr_next   = (int'(out_vc) == NUM_VC - 1) ? '0 : out_vc + 1'b1;

  always_comb begin
    push_vec = '0;
    pop_vec  = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      push_vec[v] = push_en && (in_vc == VC_W'(v));
      pop_vec[v]  = fifo_pop && (grant_vc == VC_W'(v));
    end
  end

  assign overflow_hit = push_en && vc_full[in_vc] && !pop_vec[in_vc];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr       <= '0;
      lock_vc      <= '0;
      stall_q      <= 1'b0;
      stall_vc     <= '0;
      credit_o     <= '0;
      err_overflow <= 1'b0;
      err_badvc    <= 1'b0;
    end else begin
      stall_q        <= out_valid && !out_ready;
      stall_vc       <= out_vc;
      credit_o.valid <= pop_fire;
      if (pop_fire) begin
        credit_o.vc <= 8'(out_vc);
        rr_ptr      <= rr_next;
      end
      if (!locked && state_nxt == LOCKED) lock_vc <= out_vc;
      if (in_valid && !in_vc_ok) err_badvc <= 1'b1;
      if (overflow_hit) err_overflow <= 1'b1;
    end
  end

endmodule
